reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Parametrised, collapsing-queue reservation station with one instance per functional-unit class (simple, complex, fp).
- Sits between dispatch and execute. It holds up to DEPTH decoded instructions and accepts up to two allocations per cycle (slot A, slot B).
- Operands wait on NUM_CDB result-broadcast ports through tag wakeup.
- Each cycle it issues the oldest instruction whose operands are both ready to the FU, using a valid/ready handshake.

Parameters:
DEPTH, 4, number of entries; must be >= 2.
DATA_W, 32, operand value width.
TAG_W, 5, producer tag width; a tag sits in operand bits [TAG_W-1:0] while the operand is not ready.
CTRL_W, 10, control payload width (rd 5 bits + ALU ctrl 5 bits).
NUM_CDB, 2, number of broadcast/wakeup ports.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all entries.
alloc_valid  in  2  [0]=slot A, [1]=slot B.
alloc_ctrl  in  2*CTRL_W  control payload; slot A in low half.
alloc_src1, alloc_src2  in  2*DATA_W each  operand value, or tag when not ready.
alloc_src1_rdy, alloc_src2_rdy  in  2 each  operand-ready flags.
alloc_ready  out  1  at least 2 entries free.
free_cnt  out  $clog2(DEPTH+1)  number of free entries.
overflow_err  out  1  one-cycle pulse: allocation attempted while alloc_ready=0.
cdb_valid  in  NUM_CDB  broadcast valid per port.
cdb_tag  in  NUM_CDB*TAG_W  broadcast tags.
cdb_data  in  NUM_CDB*DATA_W  broadcast values.
issue_valid  out  1  an instruction is offered to the FU.
issue_ready  in  1  FU accepts the offered instruction.
issue_ctrl  out  CTRL_W  control payload of the issued entry.
issue_src1, issue_src2  out  DATA_W each  operand values of the issued entry.

Behaviour:
- Reset, asynchronous: all entry valid bits = 0, issue_valid = 0, free_cnt = DEPTH, alloc_ready = 1, overflow_err = 0.
- Storage:
  - Entry i holds {valid, ctrl, src1, rdy1, src2, rdy2}.
  - Index 0 is the oldest entry; valid entries are always contiguous from index 0.
- Ready rule: an entry is ready when valid & rdy1 & rdy2, evaluated on registered state only. A wakeup becomes issuable in the cycle after the broadcast.
- Select and issue:
  - issue_* is combinational from the lowest-index ready entry. issue_valid=0 when no entry is ready.
  - Issue fires when issue_valid & issue_ready.
  - While issue_ready=0, the offered entry is held and issue_* stays stable, unless an older entry becomes ready, in which case the older entry preempts.
- Collapse on fire: at the edge, the issued entry is removed and every higher entry shifts down by one.
- Allocation:
  - Accepted only when alloc_ready=1.
  - New entries append after the collapse, at index count-fire.
  - Slot A is placed before slot B (A is older). If only B is valid, B takes the first free index.
- Overflow: any alloc_valid bit set while alloc_ready=0 drops both slots and pulses overflow_err for one cycle. State is otherwise unchanged.
- Count update: count_next = count - fire + popcount(accepted allocs).
  - free_cnt = DEPTH - count, registered.
  - alloc_ready = (free_cnt >= 2).
- Wakeup:
  - For each valid entry operand with rdy=0, a match on cdb_valid[k] & cdb_tag[k] == src[TAG_W-1:0] captures cdb_data[k] and sets rdy.
  - Wakeup applies to the entry's post-shift position when an issue fires in the same cycle.
  - If multiple ports match, the lowest k wins.
- Allocation bypass: an allocated operand with rdy=0 that matches a CDB port in the same cycle is stored already captured, with rdy=1.
- Flush: all entries become invalid at the next edge. Flush dominates same-cycle alloc and wakeup; a same-cycle issue fire is still reported to the FU. After flush, free_cnt=DEPTH.
- Reset asserted mid-operation clears everything immediately. There is no partial state.

Decomposition:
- Package rs_pkg holds:
  - default widths: DATA_W, TAG_W, CTRL_W;
  - entry field offsets matching the dispatched layout {src2, rdy2, src1, rdy1, ctrl};
  - the derived ENTRY_W.
- Sub-module rs_operand_wakeup:
  - Combinational per-operand CDB compare/capture: inputs src, rdy, cdb_*; outputs src_next, rdy_next.
  - Instantiated 2*DEPTH times for stored entries and 4 times for the allocation bypass.

Test Plan:
1. Reset -> issue_valid=0, free_cnt=4, alloc_ready=1, overflow_err=0.
2. Alloc A {ctrl=0x021, src1=5 rdy, src2=7 rdy}, B {src1=tag 3 not-rdy, src2=1 rdy}, issue_ready=1:
   - next cycle, issue ctrl=0x021, src1=5, src2=7;
   - cdb tag 3 data 0xDEAD in cycle N -> B issues in cycle N+1 with src1=0xDEAD.
3. Entry0 waits on tag 4, entry1 ready, entry2 ready, issue_ready=1 -> entry1 issues first; entry2 shifts to index 1 and issues next cycle; entry0 stays at index 0.
4. Fill 4 entries (two double-allocs) -> free_cnt=0, alloc_ready=0. A further alloc_valid=2'b01 -> overflow_err pulses once; contents unchanged.
5. Alloc with src2 = tag 9 not-rdy while cdb_valid[1]=1, cdb_tag[1]=9, data=0x1234 -> entry issuable next cycle with src2=0x1234. issue_ready=0 for 3 cycles -> issue_* stable.
6. flush together with alloc, issue fire and a CDB match -> next cycle free_cnt=4, issue_valid=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared widths and entry layout for the reservation station.
// Layout matches the dispatched bundle {src2, rdy2, src1, rdy1, ctrl}.
package rs_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 5;
    localparam int RS_CTRL_W = 10;

    localparam int CTRL_LSB  = 0;
    localparam int RDY1_BIT  = CTRL_LSB + RS_CTRL_W;
    localparam int SRC1_LSB  = RDY1_BIT + 1;
    localparam int RDY2_BIT  = SRC1_LSB + RS_DATA_W;
    localparam int SRC2_LSB  = RDY2_BIT + 1;
    localparam int ENTRY_W   = SRC2_LSB + RS_DATA_W;

endpackage

// File: rtl/rs_operand_wakeup.sv
// Per-operand CDB tag compare and capture.
// Lowest-numbered matching port supplies the value.
module rs_operand_wakeup #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic [DATA_W-1:0]         src,
    input  logic                      rdy,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic [DATA_W-1:0]         src_next,
    output logic                      rdy_next
);

    logic hit;

    always_comb begin
        src_next = src;
        rdy_next = rdy;
        hit      = 1'b0;
        if (!rdy) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (!hit && cdb_valid[k] &&
                    cdb_tag[k*TAG_W +: TAG_W] == src[TAG_W-1:0]) begin
                    hit      = 1'b1;
                    src_next = cdb_data[k*DATA_W +: DATA_W];
                    rdy_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: two allocs per cycle,
// CDB tag wakeup, oldest-ready issue over a valid/ready handshake.
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = RS_DATA_W,
    parameter int TAG_W   = RS_TAG_W,
    parameter int CTRL_W  = RS_CTRL_W,
    parameter int NUM_CDB = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [1:0]                alloc_valid,
    input  logic [2*CTRL_W-1:0]       alloc_ctrl,
    input  logic [2*DATA_W-1:0]       alloc_src1,
    input  logic [2*DATA_W-1:0]       alloc_src2,
    input  logic [1:0]                alloc_src1_rdy,
    input  logic [1:0]                alloc_src2_rdy,
    output logic                      alloc_ready,
    output logic [CW-1:0]             free_cnt,
    output logic                      overflow_err,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [CTRL_W-1:0]         issue_ctrl,
    output logic [DATA_W-1:0]         issue_src1,
    output logic [DATA_W-1:0]         issue_src2
);

    logic [CW-1:0]     count_q;
    logic [CTRL_W-1:0] e_ctrl [DEPTH];
    logic [DATA_W-1:0] e_src1 [DEPTH];
    logic [DATA_W-1:0] e_src2 [DEPTH];
    logic [DEPTH-1:0]  e_rdy1, e_rdy2, e_valid;

    logic [DATA_W-1:0] w_src1 [DEPTH];
    logic [DATA_W-1:0] w_src2 [DEPTH];
    logic [DEPTH-1:0]  w_rdy1, w_rdy2;

    logic [DATA_W-1:0] a_src1 [2];
    logic [DATA_W-1:0] a_src2 [2];
    logic [1:0]        a_rdy1, a_rdy2;

    logic [CTRL_W-1:0] n_ctrl [DEPTH];
    logic [DATA_W-1:0] n_src1 [DEPTH];
    logic [DATA_W-1:0] n_src2 [DEPTH];
    logic [DEPTH-1:0]  n_rdy1, n_rdy2;
    logic [CW-1:0]     n_count;

    logic [IW-1:0] sel;
    logic          found, fire, alloc_any, alloc_ok;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        rs_operand_wakeup #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
        ) u_w1 (
            .src(e_src1[i]), .rdy(e_rdy1[i]),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data),
            .src_next(w_src1[i]), .rdy_next(w_rdy1[i])
        );
        rs_operand_wakeup #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
        ) u_w2 (
            .src(e_src2[i]), .rdy(e_rdy2[i]),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data),
            .src_next(w_src2[i]), .rdy_next(w_rdy2[i])
        );
    end

    for (genvar s = 0; s < 2; s++) begin : g_byp
        rs_operand_wakeup #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
        ) u_b1 (
            .src(alloc_src1[s*DATA_W +: DATA_W]),
            .rdy(alloc_src1_rdy[s]),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data),
            .src_next(a_src1[s]), .rdy_next(a_rdy1[s])
        );
        rs_operand_wakeup #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
        ) u_b2 (
            .src(alloc_src2[s*DATA_W +: DATA_W]),
            .rdy(alloc_src2_rdy[s]),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data),
            .src_next(a_src2[s]), .rdy_next(a_rdy2[s])
        );
    end

    // Select looks only at registered state; wakeups issue a cycle later.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e_valid[i] = int'(count_q) > i;
            if (!found && e_valid[i] && e_rdy1[i] && e_rdy2[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    assign issue_valid = found;
    assign issue_ctrl  = e_ctrl[sel];
    assign issue_src1  = e_src1[sel];
    assign issue_src2  = e_src2[sel];
    assign fire        = issue_valid & issue_ready;
    assign alloc_ready = free_cnt >= CW'(2);
    assign alloc_any   = |alloc_valid;
    assign alloc_ok    = alloc_any & alloc_ready;

    always_comb begin
        int base;
        int j;
        int pos_b;
        base  = int'(count_q) - int'(fire);
        pos_b = base + int'(alloc_valid[0]);
        for (int i = 0; i < DEPTH; i++) begin
            n_ctrl[i] = e_ctrl[i];
            n_src1[i] = e_src1[i];
            n_src2[i] = e_src2[i];
            n_rdy1[i] = e_rdy1[i];
            n_rdy2[i] = e_rdy2[i];
            j = (fire && i >= int'(sel)) ? i + 1 : i;
            if (j < DEPTH) begin
                n_ctrl[i] = e_ctrl[IW'(j)];
                n_src1[i] = w_src1[IW'(j)];
                n_src2[i] = w_src2[IW'(j)];
                n_rdy1[i] = w_rdy1[IW'(j)];
                n_rdy2[i] = w_rdy2[IW'(j)];
            end
            if (alloc_ok && alloc_valid[0] && i == base) begin
                n_ctrl[i] = alloc_ctrl[0 +: CTRL_W];
                n_src1[i] = a_src1[0];
                n_src2[i] = a_src2[0];
                n_rdy1[i] = a_rdy1[0];
                n_rdy2[i] = a_rdy2[0];
            end
            if (alloc_ok && alloc_valid[1] && i == pos_b) begin
                n_ctrl[i] = alloc_ctrl[CTRL_W +: CTRL_W];
                n_src1[i] = a_src1[1];
                n_src2[i] = a_src2[1];
                n_rdy1[i] = a_rdy1[1];
                n_rdy2[i] = a_rdy2[1];
            end
        end
        n_count = CW'(base);
        if (alloc_ok)
            n_count = CW'(pos_b + int'(alloc_valid[1]));
        if (flush)
            n_count = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            free_cnt     <= CW'(DEPTH);
            overflow_err <= 1'b0;
            e_rdy1       <= '0;
            e_rdy2       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_ctrl[i] <= '0;
                e_src1[i] <= '0;
                e_src2[i] <= '0;
            end
        end else begin
            count_q      <= n_count;
            free_cnt     <= CW'(DEPTH) - n_count;
            overflow_err <= alloc_any & ~alloc_ready;
            e_rdy1       <= n_rdy1;
            e_rdy2       <= n_rdy2;
            for (int i = 0; i < DEPTH; i++) begin
                e_ctrl[i] <= n_ctrl[i];
                e_src1[i] <= n_src1[i];
                e_src2[i] <= n_src2[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an issue scoreboard.
// Expected issues are queued by the driver and popped by a monitor.
module tb_reservation_station;

    typedef struct packed {
        logic [9:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  alloc_valid = '0;
    logic [19:0] alloc_ctrl = '0;
    logic [63:0] alloc_src1 = '0, alloc_src2 = '0;
    logic [1:0]  alloc_src1_rdy = '0, alloc_src2_rdy = '0;
    logic        alloc_ready;
    logic [2:0]  free_cnt;
    logic        overflow_err;
    logic [1:0]  cdb_valid = '0;
    logic [9:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [9:0]  issue_ctrl;
    logic [31:0] issue_src1, issue_src2;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    reservation_station dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ctrl(alloc_ctrl),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .alloc_src1_rdy(alloc_src1_rdy),
        .alloc_src2_rdy(alloc_src2_rdy),
        .alloc_ready(alloc_ready), .free_cnt(free_cnt),
        .overflow_err(overflow_err),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ctrl(issue_ctrl), .issue_src1(issue_src1),
        .issue_src2(issue_src2)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic slot(int s, logic [9:0] c, logic [31:0] s1,
                        logic r1, logic [31:0] s2, logic r2);
        alloc_valid[s]          = 1'b1;
        alloc_ctrl[s*10 +: 10]  = c;
        alloc_src1[s*32 +: 32]  = s1;
        alloc_src2[s*32 +: 32]  = s2;
        alloc_src1_rdy[s]       = r1;
        alloc_src2_rdy[s]       = r2;
    endtask

    task automatic no_alloc();
        alloc_valid = '0;
    endtask

    task automatic bcast(int k, logic [4:0] t, logic [31:0] d);
        cdb_valid[k]         = 1'b1;
        cdb_tag[k*5 +: 5]    = t;
        cdb_data[k*32 +: 32] = d;
    endtask

    task automatic push(logic [9:0] c, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.c = c;
        e.a = a;
        e.b = b;
        sb.push_back(e);
    endtask

    // Monitor: every accepted issue must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && issue_valid && issue_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_issue: got %0h expected none",
                             issue_ctrl);
                end else begin
                    e = sb.pop_front();
                    chk("issue", {32'h0, issue_ctrl, issue_src1, issue_src2},
                        {32'h0, e});
                end
            end
        end
    end

    initial begin
        cyc();
        cyc();
        rst_n = 1'b1;
        neg();
        chk("rst_issue_valid", 96'(issue_valid), 96'(0));
        chk("rst_free_cnt", 96'(free_cnt), 96'(4));
        chk("rst_alloc_ready", 96'(alloc_ready), 96'(1));
        chk("rst_overflow", 96'(overflow_err), 96'(0));
        cyc();

        // Basic issue and delayed wakeup
        issue_ready = 1'b1;
        slot(0, 10'h021, 32'd5, 1'b1, 32'd7, 1'b1);
        slot(1, 10'h042, 32'd3, 1'b0, 32'd1, 1'b1);
        cyc();
        no_alloc();
        bcast(0, 5'd3, 32'hDEAD);
        push(10'h021, 32'd5, 32'd7);
        push(10'h042, 32'hDEAD, 32'd1);
        neg();
        chk("t2_first_ctrl", 96'(issue_ctrl), 96'(10'h021));
        cyc();
        cdb_valid = '0;
        neg();
        chk("t2_woken_src1", 96'(issue_src1), 96'(32'hDEAD));
        cyc();
        neg();
        chk("t2_empty", 96'(issue_valid), 96'(0));
        cyc();

        // Oldest-ready ordering with a stalled head
        issue_ready = 1'b0;
        slot(0, 10'h101, 32'd4, 1'b0, 32'd2, 1'b1);
        slot(1, 10'h102, 32'd10, 1'b1, 32'd11, 1'b1);
        cyc();
        alloc_valid[1] = 1'b0;
        slot(0, 10'h103, 32'd12, 1'b1, 32'd13, 1'b1);
        cyc();
        no_alloc();
        neg();
        chk("t3_free_cnt", 96'(free_cnt), 96'(1));
        chk("t3_alloc_ready", 96'(alloc_ready), 96'(0));
        cyc();
        push(10'h102, 32'd10, 32'd11);
        push(10'h103, 32'd12, 32'd13);
        issue_ready = 1'b1;
        neg();
        chk("t3_sel_entry1", 96'(issue_ctrl), 96'(10'h102));
        cyc();
        neg();
        chk("t3_shifted", 96'(issue_ctrl), 96'(10'h103));
        cyc();
        neg();
        chk("t3_head_wait", 96'(issue_valid), 96'(0));
        chk("t3_free_one_left", 96'(free_cnt), 96'(3));
        cyc();
        bcast(1, 5'd4, 32'h44);
        push(10'h101, 32'h44, 32'd2);
        cyc();
        cdb_valid = '0;
        neg();
        cyc();
        neg();
        chk("t3_free_all", 96'(free_cnt), 96'(4));
        cyc();

        // Fill, then overflow
        issue_ready = 1'b0;
        slot(0, 10'h201, 32'd1, 1'b1, 32'h11, 1'b1);
        slot(1, 10'h202, 32'd2, 1'b1, 32'h12, 1'b1);
        cyc();
        slot(0, 10'h203, 32'd3, 1'b1, 32'h13, 1'b1);
        slot(1, 10'h204, 32'd4, 1'b1, 32'h14, 1'b1);
        cyc();
        no_alloc();
        neg();
        chk("t4_full_free", 96'(free_cnt), 96'(0));
        chk("t4_full_ready", 96'(alloc_ready), 96'(0));
        cyc();
        slot(0, 10'h3FF, 32'hF, 1'b1, 32'hF, 1'b1);
        cyc();
        no_alloc();
        neg();
        chk("t4_ovf_pulse", 96'(overflow_err), 96'(1));
        chk("t4_ovf_free", 96'(free_cnt), 96'(0));
        chk("t4_ovf_head", 96'(issue_ctrl), 96'(10'h201));
        cyc();
        neg();
        chk("t4_ovf_clear", 96'(overflow_err), 96'(0));
        cyc();
        push(10'h201, 32'd1, 32'h11);
        push(10'h202, 32'd2, 32'h12);
        push(10'h203, 32'd3, 32'h13);
        push(10'h204, 32'd4, 32'h14);
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            if (i == 1)
                chk("t4_one_free", 96'({free_cnt, alloc_ready}),
                    96'({3'd1, 1'b0}));
            cyc();
        end
        neg();
        chk("t4_drained", 96'(free_cnt), 96'(4));
        cyc();

        // Allocation bypass, then hold while stalled
        issue_ready = 1'b0;
        slot(0, 10'h055, 32'h77, 1'b1, 32'd9, 1'b0);
        bcast(0, 5'd9, 32'hBAD);
        cdb_valid[0] = 1'b0;
        bcast(1, 5'd9, 32'h1234);
        cyc();
        no_alloc();
        cdb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("t5_hold", {31'h0, issue_valid, issue_ctrl, issue_src1,
                            issue_src2},
                {31'h0, 1'b1, 10'h055, 32'h77, 32'h1234});
            cyc();
        end
        push(10'h055, 32'h77, 32'h1234);
        issue_ready = 1'b1;
        neg();
        cyc();
        neg();
        chk("t5_empty", 96'(issue_valid), 96'(0));
        cyc();

        // Two ports match: port 0 wins
        slot(0, 10'h066, 32'd6, 1'b0, 32'd3, 1'b1);
        cyc();
        no_alloc();
        bcast(0, 5'd6, 32'hAAAA);
        bcast(1, 5'd6, 32'hBBBB);
        push(10'h066, 32'hAAAA, 32'd3);
        neg();
        chk("prio_not_yet", 96'(issue_valid), 96'(0));
        cyc();
        cdb_valid = '0;
        neg();
        cyc();

        // Flush with alloc, fire and wakeup in the same cycle
        slot(0, 10'h0AA, 32'd1, 1'b1, 32'd2, 1'b1);
        cyc();
        no_alloc();
        flush = 1'b1;
        slot(0, 10'h0BB, 32'd8, 1'b1, 32'd8, 1'b1);
        slot(1, 10'h0CC, 32'd7, 1'b0, 32'd8, 1'b1);
        bcast(0, 5'd7, 32'h77);
        push(10'h0AA, 32'd1, 32'd2);
        neg();
        cyc();
        flush = 1'b0;
        no_alloc();
        cdb_valid = '0;
        neg();
        chk("t6_free", 96'(free_cnt), 96'(4));
        chk("t6_issue", 96'(issue_valid), 96'(0));
        cyc();

        // Asynchronous reset mid-operation
        issue_ready = 1'b0;
        slot(0, 10'h111, 32'd1, 1'b1, 32'd1, 1'b1);
        slot(1, 10'h122, 32'd2, 1'b1, 32'd2, 1'b1);
        cyc();
        no_alloc();
        neg();
        chk("rst2_pre", 96'(free_cnt), 96'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_free", 96'(free_cnt), 96'(4));
        chk("rst2_issue", 96'(issue_valid), 96'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
